// File: rtl/bch_pkg.sv
// Shared BCH encoder definitions: default code geometry, controller states and the parity LFSR step.
package bch_pkg;

  localparam int N_DEF = 64;
  localparam int K_DEF = 40;
  localparam int P_DEF = 24;

  // Feedback taps land on r4, r8, r14, r19; r23 takes the feedback itself.
  localparam logic [23:0] LFSR_TAPS = 24'h884110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } state_e;

  function automatic logic [23:0] lfsr_step(input logic [23:0] r, input logic d);
    logic fb;
    fb = d ^ r[0];
    return (r >> 1) ^ (fb ? LFSR_TAPS : 24'h0);
  endfunction

endpackage

// File: rtl/bch_parity_lfsr.sv
// 24-bit parity LFSR, one step per message bit; clear wins over step.
module bch_parity_lfsr
  import bch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        clear,
  input  logic        d,
  output logic [23:0] state
);

  logic [23:0] state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= '0;
    end else if (clear) begin
      state_q <= '0;
    end else if (step) begin
      state_q <= lfsr_step(state_q, d);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/bch_enc_ctrl.sv
// Serial systematic BCH encoder controller: message bits MSB first, then parity LSB first, valid/ready paced.
// Optional BCH_ENC_ABORT_EN adds an abort input that drops the codeword in progress.
module bch_enc_ctrl
  import bch_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         rst,
`ifdef BCH_ENC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_bit,
  output logic         out_last,
  output logic         busy,
  output logic [6:0]   bit_idx
);

  localparam int P = N - K;

  if (P != 24) begin : g_p_check
    $error("bch_enc_ctrl: N-K must be 24");
  end

  localparam logic [6:0] LAST_MSG = 7'(K - 1);
  localparam logic [6:0] LAST_BIT = 7'(N - 1);
  localparam logic [6:0] PEN_BIT  = 7'(N - 2);

  state_e      state_q;
  logic [K-2:0] msg_q;
  logic [22:0] par_q;
  logic        out_bit_q;
  logic        out_valid_q;
  logic        out_last_q;
  logic        in_ready_q;
  logic        busy_q;
  logic [6:0]  bit_idx_q;

  logic        abort_w;
  logic        accept_w;
  logic        xfer_w;
  logic [23:0] lfsr_state;
  logic [23:0] par_d;

`ifdef BCH_ENC_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign accept_w = (state_q == IDLE) && in_valid && !abort_w;
  assign xfer_w   = out_valid_q && out_ready && !abort_w;

  // Parity snapshot includes the step for the final message bit being transferred now.
  assign par_d = lfsr_step(lfsr_state, out_bit_q);

  bch_parity_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (xfer_w && (state_q == MSG)),
    .clear (accept_w || (abort_w && (state_q != IDLE))),
    .d     (out_bit_q),
    .state (lfsr_state)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      msg_q       <= '0;
      par_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      bit_idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_w) begin
            state_q     <= MSG;
            msg_q       <= in_data[K-2:0];
            out_bit_q   <= in_data[K-1];
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            bit_idx_q   <= '0;
          end
        end
        MSG, PAR: begin
          if (abort_w || (xfer_w && (state_q == PAR) && (bit_idx_q == LAST_BIT))) begin
            state_q     <= IDLE;
            par_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            bit_idx_q   <= '0;
          end else if (xfer_w) begin
            bit_idx_q <= bit_idx_q + 7'd1;
            if (state_q == MSG) begin
              if (bit_idx_q == LAST_MSG) begin
                state_q   <= PAR;
                par_q     <= par_d[23:1];
                out_bit_q <= par_d[0];
              end else begin
                msg_q     <= {msg_q[K-3:0], 1'b0};
                out_bit_q <= msg_q[K-2];
              end
            end else begin
              par_q      <= par_q >> 1;
              out_bit_q  <= par_q[0];
              out_last_q <= (bit_idx_q == PEN_BIT);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign bit_idx   = bit_idx_q;

endmodule

// File: doc/bch_enc_ctrl.md
# bch_enc_ctrl

Sequencing controller for the systematic BCH encoder: accepts one K-bit message per handshake, steps the 24-bit parity LFSR once per message bit, and streams the N-bit codeword serially (message bits first, then parity) under valid/ready backpressure. It sits between the message source and the serial channel/interleaver. It owns the only instance of the parity LFSR, so the LFSR advances exactly once per accepted message bit.

## Interface
- N, 64, codeword length in bits
- K, 40, message length in bits; P = N-K = 24 (localparam, must equal 24; elaboration error otherwise)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  message available
- in_ready  out  1  controller can accept a message
- in_data  in  K  message; in_data[K-1] transmitted first
- out_valid  out  1  out_bit valid
- out_ready  in  1  sink accepts out_bit
- out_bit  out  1  current codeword bit
- out_last  out  1  high with the final (N-th) codeword bit
- busy  out  1  codeword in progress (state != IDLE)
- bit_idx  out  7  index of the bit currently presented, 0..N-1

## Operation
- States: IDLE, MSG, PAR.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: latch in_data, clear LFSR, bit_idx<=0, go MSG.
- MSG: out_valid=1, out_bit=msg[K-1-bit_idx]. On transfer (out_valid&&out_ready): LFSR steps with d=out_bit, bit_idx++. Transfer at bit_idx=K-1 -> latch LFSR state (including that final step) into par_sr, go PAR.
- PAR: out_valid=1, out_bit=par_sr[0]. On transfer: par_sr shifts right (zero-fill), bit_idx++. Transfer at bit_idx=N-1 -> IDLE.
- out_last = (state==PAR && bit_idx==N-1).
- LFSR step, fb = d ^ r[0]: r[i]<=r[i+1] for all i except r[4]<=r[5]^fb, r[8]<=r[9]^fb, r[14]<=r[15]^fb, r[19]<=r[20]^fb, r[23]<=fb. Clear sets r to 0.
- No transfer -> out_bit, bit_idx, LFSR, par_sr hold.
- in_valid ignored outside IDLE; in_data sampled only at acceptance.

## Timing
- Reset (rst=0 at edge): state IDLE, in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0, bit_idx=0, LFSR=0, par_sr=0. Reset mid-codeword discards it; nothing further emitted.
- Acceptance at edge t -> first bit valid after t. With out_ready=1: N transfers in N consecutive cycles; IDLE one cycle; minimum period N+1 cycles per codeword.
- in_ready falls the cycle after acceptance, rises the cycle after the out_last transfer.
- MSG->PAR switch bubble-free: first parity bit presented the cycle after the last message-bit transfer.
- out_bit/out_valid stable while out_valid && !out_ready.

## Configuration
- BCH_ENC_ABORT_EN defined: adds input abort (1 bit). abort=1 at an edge in MSG/PAR -> next cycle IDLE, LFSR/par_sr/bit_idx cleared, no out_last. In IDLE, abort suppresses acceptance that cycle. abort has priority over a simultaneous transfer. rst has priority over abort.
- Undefined: no abort port; codeword always completes unless rst asserted.

## Structure
- Package bch_pkg: N/K/P defaults, state enum (IDLE/MSG/PAR), LFSR tap mask 24'h884110 (taps r4, r8, r14, r19, input r23).
- Sub-module bch_parity_lfsr: 24-bit register, inputs step, clear, d; output state. Synchronous active-low rst; clear has priority over step.

## Test plan
- in_data=40'h0, out_ready=1 -> 64 zero bits in 64 consecutive cycles, out_last on bit 63, in_ready high next cycle.
- in_data=40'h00_0000_0001 -> bits 0..38 = 0, bit 39 = 1; parity 24'h884110 emitted LSB first: codeword bits 44, 48, 54, 59, 63 = 1, all others 0.
- Same message, out_ready toggling 1,0,1,0 -> identical bit sequence, each bit held while out_ready=0; out_last transfer at cycle 128 after acceptance.
- in_valid held high, three random messages -> each codeword matches the reference model, acceptance every 65 cycles, in_data changes during busy ignored.
- rst=0 at bit_idx=20 -> all outputs at reset values next cycle; next message encodes correctly from zero LFSR.
- With BCH_ENC_ABORT_EN: abort at bit_idx=50 with out_ready=1 -> next cycle IDLE, no out_last; following message correct.
